// File: rtl/row_scanout.sv
`default_nettype none
// ============================================================================
// Module  : row_scanout
// Brief   : 640x480@60 VGA scan-out of a double-buffered row RAM. Sources
//           ROW_WIDTH columns per visible line and pulses swap once per line.
//           Define ROW_CLEAR_EN to zero each pixel after it has been read.
// Revision: 1.0 - initial release
// ============================================================================
module row_scanout #(
    parameter int          ROW_WIDTH = 480,
    parameter int          H_VIS     = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_VIS     = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter logic [23:0] BG_COLOR  = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [8:0]  address_read_row,
    input  logic [23:0] data_read_row,
    output logic [8:0]  address_clear_row,
    output logic [23:0] data_clear_row,
    output logic        wren_clear,
    output logic        bank,
    output logic        swap,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de
);

    localparam logic [9:0] c_H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_H_PRE    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 2);
    localparam logic [9:0] c_V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_H_VIS    = 10'(H_VIS);
    localparam logic [9:0] c_V_VIS    = 10'(V_VIS);
    localparam logic [9:0] c_V_VIS_M1 = 10'(V_VIS - 1);
    localparam logic [9:0] c_ROW_W    = 10'(ROW_WIDTH);
    localparam logic [9:0] c_HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] c_HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] c_VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] c_VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        w_in_row;
    logic        w_sourced;
    logic        w_active;
    logic        w_hs_n;
    logic        w_vs_n;
    logic        w_swap_next;

    logic        r_s1_in_row;
    logic        r_s1_de;
    logic        r_s1_hs;
    logic        r_s1_vs;
    logic [23:0] r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_de;
    logic        r_swap;
    logic        r_bank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign w_in_row  = (r_h_cnt < c_ROW_W);
    assign w_sourced = w_in_row && (r_v_cnt < c_V_VIS);
    assign w_active  = (r_h_cnt < c_H_VIS) && (r_v_cnt < c_V_VIS);
    assign w_hs_n    = !((r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END));
    assign w_vs_n    = !((r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END));

    assign address_read_row = w_sourced ? r_h_cnt[8:0] : 9'd0;

    // Registered one cycle early so swap is high while h_cnt sits on the last column.
    assign w_swap_next = (r_h_cnt == c_H_PRE) &&
                         ((r_v_cnt == c_V_LAST) || (r_v_cnt < c_V_VIS_M1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_in_row <= 1'b0;
            r_s1_de     <= 1'b0;
            r_s1_hs     <= 1'b1;
            r_s1_vs     <= 1'b1;
        end else begin
            r_s1_in_row <= w_in_row;
            r_s1_de     <= w_active;
            r_s1_hs     <= w_hs_n;
            r_s1_vs     <= w_vs_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb <= 24'd0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_de  <= 1'b0;
        end else begin
            r_hs <= r_s1_hs;
            r_vs <= r_s1_vs;
            r_de <= r_s1_de;
            if (!r_s1_de) begin
                r_rgb <= 24'd0;
            end else if (!r_s1_in_row) begin
                r_rgb <= BG_COLOR;
            end else if (data_read_row == 24'd0) begin
                r_rgb <= BG_COLOR;
            end else begin
                r_rgb <= data_read_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_swap <= 1'b0;
            r_bank <= 1'b0;
        end else begin
            r_swap <= w_swap_next;
            if (w_swap_next) begin
                r_bank <= ~r_bank;
            end
        end
    end

`ifdef ROW_CLEAR_EN
    logic [8:0] r_s1_addr;
    logic       r_s1_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_addr <= 9'd0;
            r_s1_src  <= 1'b0;
        end else begin
            r_s1_addr <= address_read_row;
            r_s1_src  <= w_sourced;
        end
    end

    // The read bank is never written by the drawer, so clearing it cannot collide.
    assign wren_clear        = r_s1_src;
    assign address_clear_row = r_s1_addr;
`else
    assign wren_clear        = 1'b0;
    assign address_clear_row = 9'd0;
`endif

    assign data_clear_row = 24'd0;
    assign swap           = r_swap;
    assign bank           = r_bank;
    assign vga_r          = r_rgb[23:16];
    assign vga_g          = r_rgb[15:8];
    assign vga_b          = r_rgb[7:0];
    assign vga_hs         = r_hs;
    assign vga_vs         = r_vs;
    assign vga_de         = r_de;

endmodule
`default_nettype wire

// File: tb/tb_row_scanout.sv
`default_nettype none
// ============================================================================
// Module  : tb_row_scanout
// Brief   : Self-checking bench for row_scanout with a cycle model of the
//           VGA timing and row RAM, plus a reduced-timing frame instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_row_scanout;

    localparam logic [23:0] c_BG = 24'h204060;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst2_n;
    int          mode;
    int          k;
    int          checks = 0;
    int          errors = 0;
    logic        mbank;

    logic [8:0]  address_read_row, address_clear_row;
    logic [23:0] data_read_row, data_clear_row;
    logic        wren_clear, bank, swap, vga_hs, vga_vs, vga_de;
    logic [7:0]  vga_r, vga_g, vga_b;
    wire  [23:0] rgb = {vga_r, vga_g, vga_b};

    logic [8:0]  a2_rd, a2_clr;
    logic [23:0] d2_rd, d2_clr;
    logic        wr2, bank2, swap2, hs2, vs2, de2;
    logic [7:0]  r2, g2, b2;

    always #5 clk = ~clk;

    row_scanout #(.BG_COLOR(c_BG)) dut (
        .clk(clk), .rst_n(rst_n),
        .address_read_row(address_read_row), .data_read_row(data_read_row),
        .address_clear_row(address_clear_row), .data_clear_row(data_clear_row),
        .wren_clear(wren_clear), .bank(bank), .swap(swap),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de)
    );

    // Reduced timing so a whole frame fits in a short run: 80 x 19.
    row_scanout #(
        .ROW_WIDTH(40), .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .BG_COLOR(c_BG)
    ) dut_small (
        .clk(clk), .rst_n(rst2_n),
        .address_read_row(a2_rd), .data_read_row(d2_rd),
        .address_clear_row(a2_clr), .data_clear_row(d2_clr),
        .wren_clear(wr2), .bank(bank2), .swap(swap2),
        .vga_r(r2), .vga_g(g2), .vga_b(b2),
        .vga_hs(hs2), .vga_vs(vs2), .vga_de(de2)
    );

    assign d2_rd = 24'h0;

    function automatic logic [23:0] ramf(input int a, input int m);
        logic [31:0] p;
        p = a * 32'h0001_0101;
        return (m == 0) ? p[23:0] : 24'hFF0000;
    endfunction

    always @(posedge clk) data_read_row <= ramf(int'(address_read_row), mode);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @k=%0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, ".addr_rd"}, 32'(address_read_row), 0);
        chk({tag, ".addr_clr"}, 32'(address_clear_row), 0);
        chk({tag, ".data_clr"}, 32'(data_clear_row), 0);
        chk({tag, ".wren"}, 32'(wren_clear), 0);
        chk({tag, ".bank"}, 32'(bank), 0);
        chk({tag, ".swap"}, 32'(swap), 0);
        chk({tag, ".rgb"}, 32'(rgb), 0);
        chk({tag, ".hs"}, 32'(vga_hs), 1);
        chk({tag, ".vs"}, 32'(vga_vs), 1);
        chk({tag, ".de"}, 32'(vga_de), 0);
    endtask

    // Per-cycle model: after k edges the counter sits at position k, the
    // clear port reflects position k-1 and the video outputs position k-2.
    always @(negedge clk) begin
        int h, v, q, hq, vq, e_addr, e_de, e_hs, e_vs, e_wr, e_ca;
        logic [23:0] e_rgb, d;
        logic e_swap;
        if (!rst_n) begin
            mbank = 1'b0;
        end else begin
            h = k % 800;
            v = (k / 800) % 525;
            e_addr = (h < 480 && v < 480) ? h : 0;
            e_swap = (h == 799) && (v == 524 || v < 479);
            if (e_swap) mbank = ~mbank;
            if (k >= 2) begin
                q = k - 2; hq = q % 800; vq = (q / 800) % 525;
                e_de = (hq < 640 && vq < 480) ? 1 : 0;
                e_hs = (hq >= 656 && hq < 752) ? 0 : 1;
                e_vs = (vq >= 490 && vq < 492) ? 0 : 1;
                d = ramf(hq, mode);
                if (e_de == 0)          e_rgb = 24'h0;
                else if (hq >= 480)     e_rgb = c_BG;
                else if (d == 24'h0)    e_rgb = c_BG;
                else                    e_rgb = d;
            end else begin
                e_de = 0; e_hs = 1; e_vs = 1; e_rgb = 24'h0;
            end
            e_wr = 0; e_ca = 0;
`ifdef ROW_CLEAR_EN
            if (k >= 1) begin
                q = k - 1; hq = q % 800; vq = (q / 800) % 525;
                if (hq < 480 && vq < 480) begin e_wr = 1; e_ca = hq; end
            end
`endif
            chk("addr_rd", 32'(address_read_row), e_addr);
            chk("swap", 32'(swap), 32'(e_swap));
            chk("bank", 32'(bank), 32'(mbank));
            chk("rgb", 32'(rgb), 32'(e_rgb));
            chk("hs", 32'(vga_hs), e_hs);
            chk("vs", 32'(vga_vs), e_vs);
            chk("de", 32'(vga_de), e_de);
            chk("wren", 32'(wren_clear), e_wr);
            chk("addr_clr", 32'(address_clear_row), e_ca);
            chk("data_clr", 32'(data_clear_row), 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_k(input int t);
        while (k < t) @(negedge clk);
    endtask

    initial begin
        int first_de, hs_first, hs_cnt, wcnt, sw2, vs_first, vs_cnt;
        rst_n = 1'b0; rst2_n = 1'b0; mode = 0;
        repeat (3) @(posedge clk);
        #1 chk_rst("reset");
        @(negedge clk); rst_n = 1'b1;

        first_de = -1; hs_first = -1; hs_cnt = 0;
        while (k < 900) begin
            @(negedge clk);
            if (vga_de && first_de < 0) first_de = k;
            if (!vga_hs) begin
                if (hs_first < 0) hs_first = k;
                hs_cnt++;
            end
        end
        chk("first_de_k", first_de, 2);
        chk("hs_start_k", hs_first, 658);
        chk("hs_low_len", hs_cnt, 96);

        wait_k(4002); chk("l5_col0_bg", 32'(rgb), 32'(c_BG));
        wait_k(4009); chk("l5_col7", 32'(rgb), 32'h070707);
        wait_k(4502); chk("l5_col500_bg", 32'(rgb), 32'(c_BG));
        wait_k(4652); chk("l5_blank", 32'(rgb), 0);
        chk("l5_blank_de", 32'(vga_de), 0);

        // Reset lands on column 300 of line 7, after seven swaps.
        wait_k(5900);
        chk("pre_rst_de", 32'(vga_de), 1);
        chk("pre_rst_bank", 32'(bank), 1);
        #2 rst_n = 1'b0;
        #1 chk_rst("midline_reset");

        mode = 1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        wcnt = 0;
        while (k < 800) begin
            @(negedge clk);
            if (wren_clear) wcnt++;
            if (k == 12) chk("ff_row_col10", 32'(rgb), 32'hFF0000);
            if (k == 799) chk("first_swap_line0", 32'(swap), 1);
        end
`ifdef ROW_CLEAR_EN
        chk("wren_count_line0", wcnt, 480);
`else
        chk("wren_count_line0", wcnt, 0);
`endif

        @(negedge clk); rst2_n = 1'b1;
        sw2 = 0; vs_first = -1; vs_cnt = 0;
        for (int i = 1; i <= 1520; i++) begin
            @(negedge clk);
            if (swap2) sw2++;
            if (!vs2) begin
                if (vs_first < 0) vs_first = i;
                vs_cnt++;
            end
            if (i == 79) chk("small_bank_after_first_swap", 32'(bank2), 1);
        end
        chk("small_swaps_per_frame", sw2, 12);
        chk("small_bank_frame_end", 32'(bank2), 0);
        chk("small_vs_start_k", vs_first, 1122);
        chk("small_vs_low_len", vs_cnt, 160);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
